// File: rtl/wired0_defines_pkg.sv
// Shared MDU cluster types.
//  rob_rid_t     : ROB entry id carried with every result (wid)
//  iq_mdu_resp_t : MDU result as it travels to writeback {wid, result[31:0]}
//  mdu_src_e     : which MDU producer a writeback grant went to
package wired0_defines;

    localparam int ROB_RID_W = 6;

    typedef logic [ROB_RID_W-1:0] rob_rid_t;

    typedef struct packed {
        rob_rid_t    wid;
        logic [31:0] result;
    } iq_mdu_resp_t;

    typedef enum logic {
        MDU_SRC_MUL = 1'b0,
        MDU_SRC_DIV = 1'b1
    } mdu_src_e;

endpackage

// File: rtl/wired_ex_resp_fifo.sv
// Small result FIFO that decouples one MDU producer from writeback stalls.
// The head is presented combinationally so a value pushed at one edge can be
// loaded into the writeback register at the very next edge.
//  clk, rst  : clock, synchronous active-high reset
//  flush     : drops every held entry (same effect as reset, lower priority)
//  push, din : write side; push must only be asserted when !full
//  full      : registered-count full flag
//  pop, dout : read side; dout is the current head, pop must only be asserted when !empty
//  empty     : registered-count empty flag
module wired_ex_resp_fifo
    import wired0_defines::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = iq_mdu_resp_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  T     din,
    output logic full,
    input  logic pop,
    output T     dout,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // Few entries: a plain register array with asynchronous read keeps the
    // head visible in the same cycle it becomes valid.
    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     cnt_reg;

    assign full  = (cnt_reg == (AW+1)'(DEPTH));
    assign empty = (cnt_reg == '0);
    assign dout  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full))  else $error("resp_fifo: push while full");
            assert (!(pop && empty))  else $error("resp_fifo: pop while empty");
        end
    end

endmodule

// File: rtl/wired_ex_mdu_wb_arb.sv
// Merge stage of the MDU cluster: buffers multiplier and divider results in
// per-source FIFOs and round-robins them onto one registered writeback port.
//  clk, rst              : clock, synchronous active-high reset
//  flush_i               : drops every held result (FIFOs and output register)
//  mul_valid_i/ready_o   : multiplier result handshake, mul_resp_i payload
//  div_valid_i/ready_o   : divider result handshake, div_resp_i payload
//  wb_valid_o/ready_i    : writeback handshake, wb_resp_o registered payload
module wired_ex_mdu_wb_arb
    import wired0_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         mul_valid_i,
    output logic         mul_ready_o,
    input  iq_mdu_resp_t mul_resp_i,
    input  logic         div_valid_i,
    output logic         div_ready_o,
    input  iq_mdu_resp_t div_resp_i,
    output logic         wb_valid_o,
    input  logic         wb_ready_i,
    output iq_mdu_resp_t wb_resp_o
);

    logic         mul_full, mul_empty, mul_push, mul_pop;
    logic         div_full, div_empty, div_push, div_pop;
    iq_mdu_resp_t mul_head, div_head, head_sel;
    logic         load_en, any_head, both_ne, take;
    mdu_src_e     grant_src;
    logic         rr_q;   // 0: MUL preferred on the next contested grant

    // Ready comes from the registered count only: no write-through when full.
    assign mul_ready_o = !mul_full;
    assign div_ready_o = !div_full;
    assign mul_push    = mul_valid_i & mul_ready_o;
    assign div_push    = div_valid_i & div_ready_o;

    wired_ex_resp_fifo #(.DEPTH(DEPTH), .T(iq_mdu_resp_t)) u_mul_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (mul_push),
        .din   (mul_resp_i),
        .full  (mul_full),
        .pop   (mul_pop),
        .dout  (mul_head),
        .empty (mul_empty)
    );

    wired_ex_resp_fifo #(.DEPTH(DEPTH), .T(iq_mdu_resp_t)) u_div_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (div_push),
        .din   (div_resp_i),
        .full  (div_full),
        .pop   (div_pop),
        .dout  (div_head),
        .empty (div_empty)
    );

    assign load_en  = !wb_valid_o || wb_ready_i;
    assign any_head = !mul_empty || !div_empty;
    assign both_ne  = !mul_empty && !div_empty;

    always_comb begin
        grant_src = MDU_SRC_MUL;
        if (mul_empty)
            grant_src = MDU_SRC_DIV;
        else if (!div_empty && rr_q)
            grant_src = MDU_SRC_DIV;
    end

    // A flush empties the FIFOs anyway; gating keeps pops and loads out of that cycle.
    assign take     = load_en && any_head && !flush_i;
    assign mul_pop  = take && (grant_src == MDU_SRC_MUL);
    assign div_pop  = take && (grant_src == MDU_SRC_DIV);
    assign head_sel = (grant_src == MDU_SRC_MUL) ? mul_head : div_head;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wb_valid_o <= 1'b0;
            rr_q       <= 1'b0;
        end else if (load_en) begin
            wb_valid_o <= any_head;
            // Only contested grants move the pointer, so an idle source keeps priority.
            if (both_ne) rr_q <= (grant_src == MDU_SRC_MUL);
        end
    end

    // Payload needs no reset; it is qualified by wb_valid_o.
    always_ff @(posedge clk) begin
        if (take) wb_resp_o <= head_sel;
    end

endmodule

// File: tb/tb_wired_ex_mdu_wb_arb.sv
module tb_wired_ex_mdu_wb_arb;
    import wired0_defines::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush_i = 1'b0;
    logic         mul_valid_i = 1'b0;
    logic         mul_ready_o;
    iq_mdu_resp_t mul_resp_i = '0;
    logic         div_valid_i = 1'b0;
    logic         div_ready_o;
    iq_mdu_resp_t div_resp_i = '0;
    logic         wb_valid_o;
    logic         wb_ready_i = 1'b0;
    iq_mdu_resp_t wb_resp_o;

    int total = 0;
    int bad   = 0;

    iq_mdu_resp_t mq[$];
    iq_mdu_resp_t dq[$];
    int           mstreak = 0;
    int           dstreak = 0;
    logic [15:0]  mseq = '0;
    logic [15:0]  dseq = '0;

    always #5 clk = ~clk;

    wired_ex_mdu_wb_arb #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .mul_valid_i (mul_valid_i),
        .mul_ready_o (mul_ready_o),
        .mul_resp_i  (mul_resp_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_resp_i  (div_resp_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_resp_o   (wb_resp_o)
    );

    function automatic iq_mdu_resp_t mk(input logic [5:0] w, input logic [31:0] r);
        iq_mdu_resp_t x;
        x.wid    = w;
        x.result = r;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush_i = 1'b0;
        mul_valid_i = 1'b0; div_valid_i = 1'b0; wb_ready_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mul_valid_i = 1'b0; div_valid_i = 1'b0; wb_ready_i = 1'b1;
        tick(); tick();
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid_o); end
        total++; if (mul_ready_o !== 1'b1) begin bad++; $display("FAIL reset_mul_ready got=%b want=1", mul_ready_o); end
        total++; if (div_ready_o !== 1'b1) begin bad++; $display("FAIL reset_div_ready got=%b want=1", div_ready_o); end
        total++; if (dut.rr_q !== 1'b0) begin bad++; $display("FAIL reset_rr got=%b want=0", dut.rr_q); end
        rst = 1'b0;
        $display("reset: wb_valid=%b mul_ready=%b div_ready=%b", wb_valid_o, mul_ready_o, div_ready_o);
    endtask

    task automatic test_single();
        iq_mdu_resp_t exp;
        do_reset();
        wb_ready_i = 1'b1;
        mul_valid_i = 1'b1; mul_resp_i = mk(6'd5, 32'h1234);
        tick();
        mul_valid_i = 1'b0;
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL single_cyc1 got=%b want=0", wb_valid_o); end
        tick();
        exp = mk(6'd5, 32'h1234);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL single_cyc2 got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("single: wb wid=%0d result=%h", wb_resp_o.wid, wb_resp_o.result);
        tick();
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL single_cyc3 got=%b want=0", wb_valid_o); end
    endtask

    task automatic test_rr();
        iq_mdu_resp_t exp;
        do_reset();
        wb_ready_i = 1'b1;
        mul_valid_i = 1'b1; mul_resp_i = mk(6'd1, 32'h11);
        div_valid_i = 1'b1; div_resp_i = mk(6'd2, 32'h22);
        tick();
        mul_valid_i = 1'b0; div_valid_i = 1'b0;
        tick();
        exp = mk(6'd1, 32'h11);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL rr_first got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("rr: wb wid=%0d", wb_resp_o.wid);
        tick();
        exp = mk(6'd2, 32'h22);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL rr_second got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("rr: wb wid=%0d", wb_resp_o.wid);
        tick();
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", wb_valid_o); end
        // Second contested pair: priority has moved to DIV.
        mul_valid_i = 1'b1; mul_resp_i = mk(6'd3, 32'h33);
        div_valid_i = 1'b1; div_resp_i = mk(6'd4, 32'h44);
        tick();
        mul_valid_i = 1'b0; div_valid_i = 1'b0;
        tick();
        exp = mk(6'd4, 32'h44);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL rr_div_first got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("rr: wb wid=%0d", wb_resp_o.wid);
        tick();
        exp = mk(6'd3, 32'h33);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL rr_mul_second got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("rr: wb wid=%0d", wb_resp_o.wid);
        tick();
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rr_idle2 got=%b want=0", wb_valid_o); end
    endtask

    task automatic test_backpressure();
        iq_mdu_resp_t exp;
        do_reset();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mul_valid_i = 1'b1; mul_resp_i = mk(6'(10 + i), 32'hA0 + 32'(i));
            tick();
        end
        mul_resp_i = mk(6'd13, 32'hA3);   // 4th result held at the input
        for (int i = 0; i < 3; i++) begin
            exp = mk(6'd10, 32'hA0);
            total++; if (mul_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready cyc=%0d got=%b want=0", i, mul_ready_o); end
            total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", i, wb_valid_o, wb_resp_o, exp); end
            tick();
        end
        wb_ready_i = 1'b1;
        $display("bp: wb wid=%0d released", wb_resp_o.wid);
        tick();
        exp = mk(6'd11, 32'hA1);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL bp_drain1 got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        total++; if (mul_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", mul_ready_o); end
        $display("bp: wb wid=%0d", wb_resp_o.wid);
        tick();
        mul_valid_i = 1'b0;
        exp = mk(6'd12, 32'hA2);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL bp_drain2 got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("bp: wb wid=%0d", wb_resp_o.wid);
        tick();
        exp = mk(6'd13, 32'hA3);
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL bp_drain3 got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        $display("bp: wb wid=%0d", wb_resp_o.wid);
        tick();
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", wb_valid_o); end
    endtask

    task automatic test_flush();
        iq_mdu_resp_t exp;
        do_reset();
        wb_ready_i = 1'b0;
        mul_valid_i = 1'b1; div_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mul_resp_i = mk(6'(20 + i), 32'h20 + 32'(i));
            div_resp_i = mk(6'(30 + i), 32'h30 + 32'(i));
            tick();
        end
        exp = mk(6'd20, 32'h20);
        total++; if (mul_ready_o !== 1'b0 || div_ready_o !== 1'b0) begin bad++;
            $display("FAIL flush_prefull got=%b%b want=00", mul_ready_o, div_ready_o); end
        total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== exp) begin bad++;
            $display("FAIL flush_preout got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, exp); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; mul_valid_i = 1'b0; div_valid_i = 1'b0;
        total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_wb_valid got=%b want=0", wb_valid_o); end
        total++; if (mul_ready_o !== 1'b1 || div_ready_o !== 1'b1) begin bad++;
            $display("FAIL flush_readys got=%b%b want=11", mul_ready_o, div_ready_o); end
        total++; if (dut.rr_q !== 1'b0) begin bad++; $display("FAIL flush_rr got=%b want=0", dut.rr_q); end
        $display("flush: wb_valid=%b readys=%b%b", wb_valid_o, mul_ready_o, div_ready_o);
        // Inputs handshaked during a flush must be dropped.
        flush_i = 1'b1; wb_ready_i = 1'b1;
        mul_valid_i = 1'b1; mul_resp_i = mk(6'd40, 32'h40);
        div_valid_i = 1'b1; div_resp_i = mk(6'd41, 32'h41);
        tick();
        flush_i = 1'b0; mul_valid_i = 1'b0; div_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_drop cyc=%0d got=%b/%h want=0", i, wb_valid_o, wb_resp_o); end
            tick();
        end
    endtask

    // One cycle of the random run, checked against a queue model of each FIFO.
    task automatic rand_step(input bit allow_push);
        logic         pre_v, pre_r, mhs, dhs;
        iq_mdu_resp_t pre_resp, pm, pd, exp;
        int           mc, dc;
        mul_valid_i = allow_push && ($urandom_range(0, 1) == 1);
        div_valid_i = allow_push && ($urandom_range(0, 1) == 1);
        mul_resp_i  = mk(mseq[5:0], {16'h0000, mseq});
        div_resp_i  = mk(dseq[5:0], {1'b1, 15'h0000, dseq});
        wb_ready_i  = allow_push ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        total++; if (mul_ready_o !== (mq.size() != 2)) begin bad++; $display("FAIL rnd_mul_ready got=%b cnt=%0d", mul_ready_o, mq.size()); end
        total++; if (div_ready_o !== (dq.size() != 2)) begin bad++; $display("FAIL rnd_div_ready got=%b cnt=%0d", div_ready_o, dq.size()); end
        pre_v = wb_valid_o; pre_r = wb_ready_i; pre_resp = wb_resp_o;
        mhs = mul_valid_i && mul_ready_o; dhs = div_valid_i && div_ready_o;
        pm = mul_resp_i; pd = div_resp_i;
        mc = mq.size(); dc = dq.size();
        tick();
        if (pre_v && !pre_r) begin
            total++; if (wb_valid_o !== 1'b1 || wb_resp_o !== pre_resp) begin bad++;
                $display("FAIL rnd_hold got=%b/%h want=1/%h", wb_valid_o, wb_resp_o, pre_resp); end
        end else if (mc + dc == 0) begin
            total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_idle got=%b/%h want=0", wb_valid_o, wb_resp_o); end
        end else begin
            total++;
            if (wb_valid_o !== 1'b1) begin
                bad++; $display("FAIL rnd_load got=0 want=1 mcnt=%0d dcnt=%0d", mc, dc);
            end else if (wb_resp_o.result[31] == 1'b0) begin
                if (mc == 0) begin bad++; $display("FAIL rnd_mul_spurious got=%h want=none", wb_resp_o); end
                else begin
                    exp = mq.pop_front();
                    if (wb_resp_o !== exp) begin bad++; $display("FAIL rnd_mul_order got=%h want=%h", wb_resp_o, exp); end
                    mstreak = (dc != 0) ? mstreak + 1 : 0; dstreak = 0;
                end
            end else begin
                if (dc == 0) begin bad++; $display("FAIL rnd_div_spurious got=%h want=none", wb_resp_o); end
                else begin
                    exp = dq.pop_front();
                    if (wb_resp_o !== exp) begin bad++; $display("FAIL rnd_div_order got=%h want=%h", wb_resp_o, exp); end
                    dstreak = (mc != 0) ? dstreak + 1 : 0; mstreak = 0;
                end
            end
            total++; if (mstreak > 2 || dstreak > 2) begin bad++;
                $display("FAIL rnd_fair got=%0d/%0d want<=2", mstreak, dstreak); end
        end
        if (mhs) begin mq.push_back(pm); mseq++; end
        if (dhs) begin dq.push_back(pd); dseq++; end
    endtask

    task automatic test_random();
        do_reset();
        mq.delete(); dq.delete(); mstreak = 0; dstreak = 0;
        for (int c = 0; c < 4000; c++) rand_step(1'b1);
        for (int c = 0; c < 8; c++) rand_step(1'b0);
        total++; if (mq.size() != 0 || dq.size() != 0 || wb_valid_o !== 1'b0) begin bad++;
            $display("FAIL rnd_drain got=%0d/%0d/%b want=0/0/0", mq.size(), dq.size(), wb_valid_o); end
        $display("random: mul_results=%0d div_results=%0d", mseq, dseq);
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
